// File: rtl/uart_top_core_pkg.sv
// Shared constants, types and helpers for the UART transmit subsystem.
package uart_top_core_pkg;

  localparam int unsigned PORT_W     = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BAUD_SEL_W = 4;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W  = 4;
  // Wide enough for the slowest rate (333333 clocks per bit).
  localparam int unsigned CNT_W      = 19;

  localparam logic [PORT_W-1:0] TX_PORT   = 16'h0000;
  localparam logic [PORT_W-1:0] STAT_PORT = 16'h0001;

  // Transmitter activity: idle (ready for a byte) or shifting a frame out.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // Static frame-format switches as seen by the transmit engine.
  typedef struct packed {
    logic                  eight;
    logic                  pen;
    logic                  ohel;
    logic [BAUD_SEL_W-1:0] baud;
  } frame_cfg_t;

  // Clocks per bit for each baud-select index (100 MHz system clock).
  function automatic logic [CNT_W-1:0] baud_count(input logic [BAUD_SEL_W-1:0] sel);
    logic [CNT_W-1:0] n;
    n = CNT_W'(109);
    case (sel)
      4'd0:    n = CNT_W'(333333);
      4'd1:    n = CNT_W'(83333);
      4'd2:    n = CNT_W'(41667);
      4'd3:    n = CNT_W'(20833);
      4'd4:    n = CNT_W'(10417);
      4'd5:    n = CNT_W'(5208);
      4'd6:    n = CNT_W'(2604);
      4'd7:    n = CNT_W'(1736);
      4'd8:    n = CNT_W'(868);
      4'd9:    n = CNT_W'(434);
      4'd10:   n = CNT_W'(217);
      default: n = CNT_W'(109);
    endcase
    return n;
  endfunction

  // Assemble the 11-bit LSB-first frame: start, data, optional d7/parity, stop padding.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_W-1:0] d,
                                                        input frame_cfg_t        cfg);
    logic [FRAME_BITS-1:0] f;
    logic                  par;
    par    = (^d[6:0]) ^ (d[7] & cfg.eight) ^ cfg.ohel;
    f      = '1;
    f[0]   = 1'b0;
    f[7:1] = d[6:0];
    case ({cfg.eight, cfg.pen})
      2'b01: f[8] = par;
      2'b10: f[8] = d[7];
      2'b11: begin
        f[8] = d[7];
        f[9] = par;
      end
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/uart_top_core_tx_engine.sv
// Serialiser: baud counter, bit counter and shift register for one frame.
module uart_tx_engine
  import uart_top_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  frame_cfg_t        cfg,
  input  logic [DATA_W-1:0] din,
  output logic              tx,
  output logic              txrdy
);

  tx_state_e              state;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]       baud_cnt;
  logic [CNT_W-1:0]       baud_n;
  logic                   bit_end_c;
  logic                   last_bit_c;

  // End of the current bit period and of the final frame bit.
  assign bit_end_c  = (baud_cnt == (baud_n - CNT_W'(1)));
  assign last_bit_c = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

  assign txrdy = (state == ST_IDLE);

  // Frame sequencing; tx tracks shift_reg[0] as a register of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '1;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      baud_n    <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state     <= ST_SEND;
            shift_reg <= build_frame(din, cfg);
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            baud_n    <= baud_count(cfg.baud);
            tx        <= 1'b0;
          end
        end
        ST_SEND: begin
          if (bit_end_c) begin
            baud_cnt  <= '0;
            if (last_bit_c) begin
              state     <= ST_IDLE;
              shift_reg <= '1;
              bit_cnt   <= '0;
              tx        <= 1'b1;
            end else begin
              shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
              bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_top_core.sv
// CPU port-bus front end: address decode, load qualification and status read mux.
module uart_top_core
  import uart_top_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  eight,
  input  logic                  pen,
  input  logic                  ohel,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  input  logic [BAUD_SEL_W-1:0] baud,
  input  logic [DATA_W-1:0]     out_port,
  input  logic [PORT_W-1:0]     port_id,
  output logic [DATA_W-1:0]     data,
  output logic                  tx
);

  frame_cfg_t cfg;
  logic       load_c;
  logic       txrdy;
  logic       unused_read;

  // Reads have no side effects, so the read qualifier is not needed.
  assign unused_read = read_strobe;

  assign cfg = '{eight: eight, pen: pen, ohel: ohel, baud: baud};

  // Accept a byte only when the transmitter is idle.
  assign load_c = write_strobe && (port_id == TX_PORT) && txrdy;

  uart_tx_engine u_engine (
    .clk   (clk),
    .rst_n (reset),
    .load  (load_c),
    .cfg   (cfg),
    .din   (out_port),
    .tx    (tx),
    .txrdy (txrdy)
  );

  // Status read mux; any other address reads as zero.
  always_comb begin
    data = '0;
    if (port_id == STAT_PORT) begin
      data = {7'b0, txrdy};
    end
  end

endmodule

// File: tb/tb_uart_top_core.sv
// Self-checking bench for uart_top_core against a frame-level reference model.
module tb_uart_top_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        eight = 1'b0;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic        write_strobe = 1'b0;
  logic        read_strobe = 1'b0;
  logic [3:0]  baud = 4'd0;
  logic [7:0]  out_port = 8'h00;
  logic [15:0] port_id = 16'h0000;
  logic [7:0]  data;
  logic        tx;

  int errors = 0;
  int checks = 0;

  int baud_tab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                        868, 434, 217, 109, 109, 109, 109, 109};

  uart_top_core dut (
    .clk          (clk),
    .reset        (reset),
    .eight        (eight),
    .pen          (pen),
    .ohel         (ohel),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .baud         (baud),
    .out_port     (out_port),
    .port_id      (port_id),
    .data         (data),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected line level for bit k of the frame carrying d.
  function automatic int frame_bit(input logic [7:0] d, input logic e, input logic p,
                                   input logic o, input int k);
    bit q[$];
    bit par;
    int nbits;
    nbits = e ? 8 : 7;
    par = o;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(d[i]);
      par ^= d[i];
    end
    if (p) q.push_back(par);
    while (q.size() < 11) q.push_back(1'b1);
    return int'(q[k]);
  endfunction

  // Write a byte, scramble the switches, and check the frame bit by bit.
  task automatic send_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                            input logic [3:0] b, input int busy_at, input int abort_at);
    int n;
    n = baud_tab[b];
    eight = e; pen = p; ohel = o; baud = b;
    out_port = d; port_id = 16'h0000; write_strobe = 1'b1;
    @(posedge clk); #1;
    write_strobe = 1'b0; port_id = 16'h0001;
    eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom); baud = 4'($urandom);
    for (int j = 0; j <= 11 * n; j++) begin
      if (j == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_rdy", 32'(data), 32'h01);
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      if (j == busy_at) begin
        port_id = 16'h0000; out_port = 8'h55; write_strobe = 1'b1;
      end else if (j == busy_at + 1) begin
        write_strobe = 1'b0; port_id = 16'h0001;
      end
      if (j < 11 * n && (j % n == 0 || j % n == n - 1))
        check($sformatf("tx_bit%0d_d%02h", j / n, d), 32'(tx), 32'(frame_bit(d, e, p, o, j / n)));
      if (j == 11 * n - 1) check("busy_stat", 32'(data), 32'h00);
      if (j == 11 * n) begin
        check("done_stat", 32'(data), 32'h01);
        check("done_tx", 32'(tx), 32'd1);
      end
      if (j < 11 * n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    // Reset state while held.
    port_id = 16'h0001;
    #22;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_stat", 32'(data), 32'h01);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_stat", 32'(data), 32'h01);
    check("post_rst_tx", 32'(tx), 32'd1);

    // Directed frames: 7-bit no parity, 8-bit even and odd parity.
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 4'd11, -1, -1);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0, 4'd11, -1, -1);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 4'd11, -1, -1);

    // Write while busy is ignored.
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 4'd11, 300, -1);

    // Write to an unrelated port starts nothing; port 0 reads zero.
    port_id = 16'h0005; out_port = 8'h33; write_strobe = 1'b1;
    @(posedge clk); #1;
    write_strobe = 1'b0; port_id = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(posedge clk);
      #1;
      check("p5_tx", 32'(tx), 32'd1);
    end
    check("p5_stat", 32'(data), 32'h01);
    port_id = 16'h0000;
    #1;
    check("rd_port0", 32'(data), 32'h00);
    port_id = 16'h0001;
    @(posedge clk); #1;

    // Reset during bit 4 aborts; next frame is clean.
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 4'd11, -1, 4 * 109 + 10);
    check("after_abort_stat", 32'(data), 32'h01);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 4'd11, -1, -1);

    // Randomised back-to-back frames.
    for (int f = 0; f < 8; f++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom_range(15, 10)), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
